// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: raw sensor lines and busy in, coin code, reject pulse and queue level out.
interface coin_acceptor_if #(
   parameter int unsigned FIFO_DEPTH = 4
) ();

   localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

   logic            nickel_det;
   logic            dime_det;
   logic            busy;
   logic [2:0]      coin;
   logic            coin_return;
   logic [LvlW-1:0] fifo_level;

   // Sensor/vending side: drives raw sensors and busy, consumes coin codes.
   modport master (
      output nickel_det,
      output dime_det,
      output busy,
      input  coin,
      input  coin_return,
      input  fifo_level
   );

   // Acceptor side.
   modport slave (
      input  nickel_det,
      input  dime_det,
      input  busy,
      output coin,
      output coin_return,
      output fifo_level
   );

endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces the nickel/dime sensors, queues detected
// coins and offers them one at a time to the vending FSM, never while it is dispensing.
module coin_acceptor #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input logic            clock,
   input logic            reset,
   coin_acceptor_if.slave bus_io
);

   // Counter only ever holds 0 .. DEBOUNCE_CYCLES-1.
   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned LvlW = PtrW + 1;

   // Channel 0 = nickel, channel 1 = dime.
   logic [1:0]      raw;
   logic [1:0]      sync1_q;
   logic [1:0]      sync2_q;
   logic [1:0]      level_q;
   logic [1:0]      rise_q;
   logic [CntW-1:0] cnt_q [2];

   logic [1:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [LvlW-1:0] count_q;
   logic [LvlW-1:0] count_d;
   logic [2:0]      coin_q;
   logic            ret_q;

   logic            push_req;
   logic [1:0]      push_code;
   logic            jam;
   logic            full;
   logic            pop;
   logic            push;
   logic            overflow;

   assign raw = {bus_io.dime_det, bus_io.nickel_det};

   // Two-flop synchroniser plus per-channel debounce; rise_q marks the debounced 0->1 edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
         rise_q  <= '0;
         for (int c = 0; c < 2; c++) begin
            cnt_q[c] <= '0;
         end
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         for (int c = 0; c < 2; c++) begin
            rise_q[c] <= 1'b0;
            if (sync2_q[c] == level_q[c]) begin
               cnt_q[c] <= '0;
            end else if (cnt_q[c] == CntW'(DEBOUNCE_CYCLES - 1)) begin
               // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
               level_q[c] <= ~level_q[c];
               rise_q[c]  <= ~level_q[c];
               cnt_q[c]   <= '0;
            end else begin
               cnt_q[c] <= cnt_q[c] + 1'b1;
            end
         end
      end
   end

   // Classify events, decide push/pop and reject conditions for this edge.
   always_comb begin
      push_req  = rise_q[0] ^ rise_q[1];
      jam       = rise_q[0] & rise_q[1];
      push_code = rise_q[1] ? 2'd2 : 2'd1;
      full      = (count_q == LvlW'(FIFO_DEPTH));
      // coin_q == 0 is the gap flag: guarantees a zero cycle between offered coins.
      pop       = (count_q != '0) && !bus_io.busy && (coin_q == 3'd0);
      push      = push_req && (!full || pop);
      overflow  = push_req && full && !pop;
      count_d   = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   // Coin queue storage, pointers, level and the registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         coin_q   <= 3'd0;
         ret_q    <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_code;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
         coin_q  <= pop ? {1'b0, mem_q[rd_ptr_q]} : 3'd0;
         ret_q   <= jam | overflow;
      end
   end

   assign bus_io.coin        = coin_q;
   assign bus_io.coin_return = ret_q;
   assign bus_io.fifo_level  = count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus random sensor/busy traffic,
// all compared cycle by cycle against a behavioural model of the acceptor.
module tb_coin_acceptor;

   localparam int unsigned DEB   = 4;
   localparam int unsigned DEPTH = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;

   always #5 clock = ~clock;

   coin_acceptor_if #(.FIFO_DEPTH(DEPTH)) bus ();

   coin_acceptor #(
      .DEBOUNCE_CYCLES(DEB),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus_io(bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int unsigned    m_q[$];         // queued coin codes in detection order
   bit             m_s1[2];
   bit             m_s2[2];
   bit             m_lvl[2];       // debounced level
   bit             m_pend[2];      // debounced rise seen, to be classified next edge
   logic [DEB-1:0] m_win[2];       // most recent synchronised samples
   int unsigned    m_nwin[2];      // samples in window since last level change
   int unsigned    m_coin;
   bit             m_ret;

   task automatic model_reset();
      m_q.delete();
      for (int c = 0; c < 2; c++) begin
         m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_pend[c] = 0;
         m_win[c] = '0; m_nwin[c] = 0;
      end
      m_coin = 0;
      m_ret  = 0;
   endtask

   // One clock edge of the acceptor, from the rules: a level changes once the last DEB
   // synchronised samples all disagree with it; rises are classified and queued next edge.
   task automatic model_edge();
      bit             raw[2];
      bit             pop;
      bit             push_ok;
      int unsigned    code;
      logic [DEB-1:0] all_diff;
      raw[0]  = bus.nickel_det;
      raw[1]  = bus.dime_det;
      pop     = (m_q.size() != 0) && !bus.busy && (m_coin == 0);
      push_ok = 0;
      m_ret   = 0;
      code    = m_pend[1] ? 2 : 1;
      if (m_pend[0] && m_pend[1]) begin
         m_ret = 1;
      end else if (m_pend[0] || m_pend[1]) begin
         if (m_q.size() == DEPTH && !pop) m_ret = 1;
         else push_ok = 1;
      end
      if (pop) m_coin = m_q.pop_front();
      else m_coin = 0;
      if (push_ok) m_q.push_back(code);
      for (int c = 0; c < 2; c++) begin
         m_pend[c] = 0;
         m_win[c]  = (m_win[c] << 1) | DEB'(m_s2[c]);
         if (m_nwin[c] < DEB) m_nwin[c]++;
         all_diff = m_lvl[c] ? '0 : '1;
         if (m_nwin[c] == DEB && m_win[c] == all_diff) begin
            m_lvl[c]  = ~m_lvl[c];
            m_pend[c] = m_lvl[c];
            m_nwin[c] = 0;
         end
         m_s2[c] = m_s1[c];
         m_s1[c] = raw[c];
      end
   endtask

   // ---------------- vending FSM stand-in and logs ----------------
   bit          vend_en   = 0;
   bit          vend_pend = 0;
   int unsigned credit    = 0;
   int unsigned papers    = 0;
   int unsigned seen[$];
   int unsigned n_ret     = 0;

   task automatic step();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check("coin", bus.coin, m_coin);
      check("coin_return", bus.coin_return, m_ret);
      check("fifo_level", bus.fifo_level, m_q.size());
      if (bus.coin != 3'd0) seen.push_back(bus.coin);
      if (bus.coin_return) n_ret++;
      if (vend_en) begin
         // Registered newspaper output: busy follows the coin that completed 15 by one edge.
         bus.busy = vend_pend;
         credit += (bus.coin == 3'd1) ? 5 : (bus.coin == 3'd2) ? 10 : 0;
         if (credit >= 15) begin
            vend_pend = 1;
            credit    = 0;
            papers++;
         end else begin
            vend_pend = 0;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   int unsigned base;
   int unsigned ret0;
   int unsigned lat;
   int unsigned ones;
   int unsigned hold[2];

   initial begin
      bus.nickel_det = 1'b0;
      bus.dime_det   = 1'b0;
      bus.busy       = 1'b0;
      model_reset();
      #1 reset = 1'b1;
      #1;
      check("rst_coin", bus.coin, 0);
      check("rst_ret", bus.coin_return, 0);
      check("rst_level", bus.fifo_level, 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Single nickel: latency E0 + DEB + 3, one coin, no reject.
      bus.nickel_det = 1'b1;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 10) bus.nickel_det = 1'b0;
         if (bus.coin != 3'd0 && lat == 0) lat = i;
      end
      check("latency", lat, DEB + 4);
      check("s1_coins", seen.size(), 1);
      check("s1_ret", n_ret, 0);

      // Short pulse and bounce train: no event.
      base = seen.size();
      bus.nickel_det = 1'b1; run(3);
      bus.nickel_det = 1'b0; run(3);
      for (int i = 0; i < 5; i++) begin
         bus.nickel_det = 1'b1; step();
         bus.nickel_det = 1'b0; step();
      end
      run(12);
      check("s2_coins", seen.size() - base, 0);
      check("s2_ret", n_ret, 0);

      // Nickel, dime, dime with busy from the vending FSM.
      vend_en = 1; credit = 0; papers = 0; vend_pend = 0;
      base = seen.size();
      for (int k = 0; k < 3; k++) begin
         if (k == 0) bus.nickel_det = 1'b1; else bus.dime_det = 1'b1;
         run(6);
         bus.nickel_det = 1'b0; bus.dime_det = 1'b0;
         run(6);
      end
      run(20);
      vend_en  = 0;
      bus.busy = 1'b0;
      check("s3_count", seen.size() - base, 3);
      if (seen.size() - base == 3) begin
         check("s3_first", seen[base], 1);
         check("s3_second", seen[base + 1], 2);
         check("s3_third", seen[base + 2], 2);
      end
      check("s3_papers", papers, 1);
      check("s3_credit", credit, 10);

      // Five nickels while busy: saturate at DEPTH, one overflow reject, then drain.
      bus.busy = 1'b1;
      ret0 = n_ret;
      for (int k = 0; k < 5; k++) begin
         bus.nickel_det = 1'b1; run(6);
         bus.nickel_det = 1'b0; run(6);
      end
      run(4);
      check("s4_level", bus.fifo_level, DEPTH);
      check("s4_ret", n_ret - ret0, 1);
      bus.busy = 1'b0;
      base = seen.size();
      run(12);
      ones = 0;
      for (int i = base; i < seen.size(); i++) if (seen[i] == 1) ones++;
      check("s4_drain", seen.size() - base, DEPTH);
      check("s4_codes", ones, DEPTH);

      // Jam: both sensors rise together.
      ret0 = n_ret;
      base = seen.size();
      bus.nickel_det = 1'b1; bus.dime_det = 1'b1; run(8);
      bus.nickel_det = 1'b0; bus.dime_det = 1'b0; run(10);
      check("s5_ret", n_ret - ret0, 1);
      check("s5_coins", seen.size() - base, 0);

      // Reset with three coins queued and one mid-debounce.
      bus.busy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.nickel_det = 1'b1; run(6);
         bus.nickel_det = 1'b0; run(6);
      end
      check("s6_pre_level", bus.fifo_level, 3);
      bus.nickel_det = 1'b1; run(3);
      #2 reset = 1'b1;
      bus.nickel_det = 1'b0;
      bus.busy       = 1'b0;
      #1;
      check("s6_rst_level", bus.fifo_level, 0);
      check("s6_rst_coin", bus.coin, 0);
      check("s6_rst_ret", bus.coin_return, 0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      base = seen.size();
      ret0 = n_ret;
      run(25);
      check("s6_coins", seen.size() - base, 0);
      check("s6_ret", n_ret - ret0, 0);

      // Random sensor and busy traffic.
      hold[0] = 0; hold[1] = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold[0] == 0) begin
            bus.nickel_det = 1'($urandom_range(0, 1));
            hold[0] = $urandom_range(1, 9);
         end
         if (hold[1] == 0) begin
            bus.dime_det = 1'($urandom_range(0, 1));
            hold[1] = $urandom_range(1, 9);
         end
         hold[0]--; hold[1]--;
         bus.busy = ($urandom_range(0, 3) == 0);
         step();
      end
      bus.nickel_det = 1'b0; bus.dime_det = 1'b0; bus.busy = 1'b0;
      run(30);
      check("rand_drain", bus.fifo_level, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end stage that feeds the newspaper vending FSM. It synchronises and debounces the raw nickel/dime sensor lines and queues each detected coin in a small FIFO. It then presents queued coins one at a time on the 3-bit coin code the vending FSM consumes. Coins are never presented while the vending FSM is dispensing, so no credit is lost; jams and overflows are returned to the customer.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before a sensor's debounced level changes (>=1)
FIFO_DEPTH, 4, coin queue entries (power of 2, >=2)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
nickel_det  input  1  raw nickel sensor, asynchronous to clock, high while coin in slot
dime_det  input  1  raw dime sensor, asynchronous to clock, high while coin in slot
busy  input  1  vending FSM dispensing (driven from its newspaper output); coin must not be presented
coin  output  3  registered coin code: 0 = nocoin, 1 = nickel, 2 = dime; other codes never driven
coin_return  output  1  registered one-cycle pulse: physical coin rejected (jam or overflow)
fifo_level  output  $clog2(FIFO_DEPTH)+1  current queued-coin count

Behaviour:
- Reset (async, immediate): coin = 0, coin_return = 0, fifo_level = 0. Sync flops, debounce counters, debounced levels, FIFO pointers and the gap flag all clear. Reset mid-operation discards all queued and in-flight coins; no pulse is emitted on reset release.
- Synchronisation: each sensor passes through 2 flops.
- Debounce, per channel:
  - A counter increments while the sync output differs from the debounced level and clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Event: a 0->1 transition of a debounced level, one cycle wide. Falling transitions produce no event.
- Classification, per cycle:
  - Nickel event only: push code 1.
  - Dime event only: push code 2.
  - Both events in the same cycle: jam. coin_return pulses on the next cycle and nothing is pushed.
- FIFO:
  - A push when fifo_level == FIFO_DEPTH and no pop in the same cycle is an overflow: coin_return pulses next cycle, the coin is dropped, and the FIFO is unchanged.
  - Push and pop in the same cycle are both accepted; level is unchanged. A push into a full FIFO with a simultaneous pop is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- Output / pop rule, evaluated at each edge:
  - Pop the head into coin only if the FIFO is non-empty, busy == 0 in the current cycle, and coin == 0 in the current cycle (gap flag).
  - Otherwise coin <= 0.
  - coin is therefore non-zero for exactly 1 cycle per coin, with at least one zero cycle between consecutive coins. This lets the vending FSM's dispense state raise busy before the next coin is offered.
- Latency, idle queue, busy = 0: raw sensor high and stable from before edge E0 gives coin non-zero in the cycle after edge E0 + DEBOUNCE_CYCLES + 3. This covers 2 sync edges, DEBOUNCE_CYCLES count edges, 1 push edge and 1 pop edge, with the edges counted from E0.
- While busy = 1: no pop. The head is held and coins keep queuing.
- Ordering: coins are presented in detection order.
- fifo_level is updated on the same edge as each push/pop.

Test Plan:
- DEBOUNCE_CYCLES=4. Nickel pulse held 10 cycles -> coin = 1 for exactly one cycle at E0+7; fifo_level goes 0 -> 1 -> 0; coin_return stays 0.
- Nickel pulse 3 cycles wide (shorter than debounce), plus a bounce train of 1-cycle pulses -> no coin, no coin_return, fifo_level stays 0.
- Nickel, dime, dime spaced 12 cycles apart, with busy modelled from the vending FSM (one cycle high after credit >= 15) -> coin sequence 1, 2, 2. No coin is ever presented in a cycle where busy = 1, and every coin is separated by >= 1 zero cycle. The downstream FSM sees 15 then a fresh 10.
- busy held 1 while 5 nickels arrive, FIFO_DEPTH=4 -> fifo_level saturates at 4, exactly one coin_return pulse on the 5th coin. After busy drops, 4 coins of code 1 emerge on alternate cycles.
- Both sensors rise simultaneously -> one coin_return pulse, coin stays 0, fifo_level stays 0.
- Reset asserted with 3 coins queued and one mid-debounce -> coin, coin_return and fifo_level go to 0 asynchronously. After release with sensors low, no coin is ever emitted.
